// File: rtl/hazard_unit_gen.sv
// hazard_unit_gen: N-stage pipeline hazard controller.
// Turns per-stage hazard requests into per-register stall/flush controls,
// arbitrates PC redirects (oldest stage wins), keeps saturating per-stage
// statistics with a registered readout, and flags a stalled-IF deadlock.
//
// Handshake: there is no valid/ready pair here; load_pc_we is a one-cycle
// strobe that is high exactly in the cycle the redirect is accepted, and the
// requester must hold redir_valid until it observes load_pc_we.
module hazard_unit_gen #(
  parameter int NUM_STAGES  = 5,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32,
  parameter int DELAY_SLOT  = 1,
  parameter int WDOG_CYCLES = 1024,
  localparam int NUM_CNT    = 3 * NUM_STAGES,
  localparam int SEL_W      = $clog2(NUM_CNT),
  localparam int WIN_W      = $clog2(NUM_STAGES),
  localparam int WD_W       = $clog2(WDOG_CYCLES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_STAGES-1:0]        hz_req,
  input  logic [NUM_STAGES-1:0]        redir_valid,
  input  logic [NUM_STAGES*ADDR_W-1:0] redir_target,
  output logic [NUM_STAGES-1:0]        stall_o,
  output logic [NUM_STAGES-1:0]        flush_o,
  output logic                         load_pc_we,
  output logic [ADDR_W-1:0]            load_pc_new_pc,
  input  logic                         stat_clear,
  input  logic [SEL_W-1:0]             stat_sel,
  output logic [CNT_W-1:0]             stat_data,
  output logic                         deadlock
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CNT - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(WDOG_CYCLES - 1);

  // Stage 0 (IF) never issues a redirect.
  logic unused_redir_valid0;
  assign unused_redir_valid0 = redir_valid[0];

  logic [NUM_STAGES-1:1] blk;
  logic [WIN_W-1:0]      win;
  logic                  any_redir;
  logic                  acc;
  logic                  stalling;

  logic [CNT_W-1:0]      cnt_q [NUM_CNT];
  logic [CNT_W-1:0]      cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0]    inc;
  logic [NUM_STAGES-1:0] prev_hz_q;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  dl_q, dl_d;
  logic [CNT_W-1:0]      stat_data_q, stat_data_d;

  // Blocking chain: a stage is held if it or any older stage is stuck.
  always_comb begin
    blk = '0;
    blk[NUM_STAGES-1] = hz_req[NUM_STAGES-1];
    for (int s = NUM_STAGES - 2; s >= 1; s--) begin
      blk[s] = hz_req[s] | blk[s+1];
    end
  end

  // Redirect arbitration: the highest-index valid stage (oldest) wins.
  always_comb begin
    win = '0;
    for (int r = 1; r < NUM_STAGES; r++) begin
      if (redir_valid[r]) win = WIN_W'(r);
    end
    any_redir = |redir_valid[NUM_STAGES-1:1];
    acc       = ~blk[1] & any_redir;
  end

  // Stall/flush/PC outputs; a redirect overrides an IF-only hazard.
  always_comb begin
    load_pc_we     = acc;
    load_pc_new_pc = acc ? redir_target[win*ADDR_W +: ADDR_W] : '0;
    stall_o        = {blk, (hz_req[0] & ~acc) | blk[1]};
    for (int s = 0; s < NUM_STAGES; s++) begin
      flush_o[s] = hz_req[s] | (acc & (s < (int'(win) - DELAY_SLOT)));
    end
    stalling = stall_o[0] & ~acc;
  end

  // Counter next state: clear wins over increment, increments saturate.
  always_comb begin
    inc = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      inc[3*s]     = hz_req[s];
      inc[3*s + 1] = hz_req[s] & ~prev_hz_q[s];
      inc[3*s + 2] = (s != 0) & acc & (win == WIN_W'(s));
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clear)                     cnt_d[i] = '0;
      else if (inc[i] && (~&cnt_q[i]))    cnt_d[i] = cnt_q[i] + 1'b1;
    end
    stat_data_d = (stat_sel <= LAST_SEL) ? cnt_q[stat_sel] : '0;
  end

  // Watchdog: count consecutive IF stalls, set sticky deadlock at the limit.
  always_comb begin
    wd_d = wd_q;
    dl_d = dl_q;
    if (stat_clear) begin
      wd_d = '0;
      dl_d = 1'b0;
    end else if (stalling) begin
      if (wd_q == WD_MAX) dl_d = 1'b1;
      else                wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      prev_hz_q   <= '0;
      wd_q        <= '0;
      dl_q        <= 1'b0;
      stat_data_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      prev_hz_q   <= hz_req;
      wd_q        <= wd_d;
      dl_q        <= dl_d;
      stat_data_q <= stat_data_d;
    end
  end

  assign stat_data = stat_data_q;
  assign deadlock  = dl_q;

endmodule

// File: tb/tb_hazard_unit_gen.sv
// Bench for hazard_unit_gen: two instances (delay slot on/off) driven by the
// same stimulus, checked every cycle against a behavioural model, plus
// hand-computed literal expectations from the directed scenarios.
module tb_hazard_unit_gen;

  localparam int N  = 5;
  localparam int A  = 32;
  localparam int CW = 4;
  localparam int WD = 8;
  localparam int NC = 3 * N;
  localparam int SW = $clog2(NC);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   hz_req;
  logic [N-1:0]   redir_valid;
  logic [N*A-1:0] redir_target;
  logic           stat_clear;
  logic [SW-1:0]  stat_sel;

  logic [N-1:0]  stall0, stall1, flush0, flush1;
  logic          we0, we1, dl0, dl1;
  logic [A-1:0]  pc0, pc1;
  logic [CW-1:0] sd0, sd1;

  hazard_unit_gen #(.NUM_STAGES(N), .ADDR_W(A), .CNT_W(CW), .DELAY_SLOT(1), .WDOG_CYCLES(WD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hz_req(hz_req), .redir_valid(redir_valid),
    .redir_target(redir_target), .stall_o(stall0), .flush_o(flush0),
    .load_pc_we(we0), .load_pc_new_pc(pc0), .stat_clear(stat_clear),
    .stat_sel(stat_sel), .stat_data(sd0), .deadlock(dl0));

  hazard_unit_gen #(.NUM_STAGES(N), .ADDR_W(A), .CNT_W(CW), .DELAY_SLOT(0), .WDOG_CYCLES(WD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hz_req(hz_req), .redir_valid(redir_valid),
    .redir_target(redir_target), .stall_o(stall1), .flush_o(flush1),
    .load_pc_we(we1), .load_pc_new_pc(pc1), .stat_clear(stat_clear),
    .stat_sel(stat_sel), .stat_data(sd1), .deadlock(dl1));

  // ---------------- scoreboard counters ----------------
  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_cnt [NC];
  logic [N-1:0] m_prev;
  int   m_wd;
  bit   m_dl;
  int   m_sd;
  localparam int SAT = (1 << CW) - 1;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_prev = '0;
    m_wd   = 0;
    m_dl   = 0;
    m_sd   = 0;
  endtask

  // Combinational rules: a stage s>=1 is held if any stage s..N-1 is stuck;
  // oldest redirect wins when stage 1 is free.
  task automatic model_comb(input int ds, output logic [N-1:0] st, output logic [N-1:0] fl,
                            output logic we, output logic [A-1:0] pc, output int win);
    int  w;
    bit  acc;
    w  = 0;
    st = '0;
    fl = '0;
    for (int r = 1; r < N; r++) if (redir_valid[r]) w = r;
    for (int s = 1; s < N; s++)
      for (int j = s; j < N; j++) if (hz_req[j]) st[s] = 1'b1;
    acc   = (w != 0) && !st[1];
    st[0] = (hz_req[0] && !acc) || st[1];
    for (int s = 0; s < N; s++) fl[s] = hz_req[s] || (acc && (s < w - ds));
    we  = acc;
    pc  = acc ? redir_target[w*A +: A] : '0;
    win = acc ? w : 0;
  endtask

  // Compare every output of both instances against the model.
  task automatic settle();
    logic [N-1:0] st, fl, st_b, fl_b;
    logic we, we_b;
    logic [A-1:0] pc, pc_b;
    int win;
    @(negedge clk);
    model_comb(1, st, fl, we, pc, win);
    model_comb(0, st_b, fl_b, we_b, pc_b, win);
    chk("stall0", stall0, st);
    chk("flush0", flush0, fl);
    chk("we0", we0, we);
    chk("pc0", pc0, pc);
    chk("sd0", sd0, m_sd);
    chk("dl0", dl0, m_dl);
    chk("stall1", stall1, st_b);
    chk("flush1", flush1, fl_b);
    chk("we1", we1, we_b);
    chk("pc1", pc1, pc_b);
    chk("sd1", sd1, m_sd);
    chk("dl1", dl1, m_dl);
  endtask

  // Apply one clock edge to the model with the current inputs, then to the DUT.
  task automatic advance();
    logic [N-1:0] st, fl;
    logic we;
    logic [A-1:0] pc;
    int win;
    int nsd;
    model_comb(1, st, fl, we, pc, win);
    nsd = (int'(stat_sel) < NC) ? m_cnt[stat_sel] : 0;
    for (int s = 0; s < N; s++) begin
      bit ev [3];
      ev[0] = hz_req[s];
      ev[1] = hz_req[s] && !m_prev[s];
      ev[2] = we && (win == s);
      for (int k = 0; k < 3; k++) begin
        if (stat_clear) m_cnt[3*s+k] = 0;
        else if (ev[k] && m_cnt[3*s+k] < SAT) m_cnt[3*s+k]++;
      end
    end
    if (stat_clear) begin
      m_wd = 0;
      m_dl = 0;
    end else if (st[0] && !we) begin
      if (m_wd == WD - 1) m_dl = 1;
      else m_wd++;
    end else begin
      m_wd = 0;
    end
    m_prev = hz_req;
    m_sd   = nsd;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    hz_req       = '0;
    redir_valid  = '0;
    redir_target = '0;
    stat_clear   = 1'b0;
    stat_sel     = '0;
    model_reset();
    #3;
    chk("rst_sd", sd0, 0);
    chk("rst_dl", dl0, 0);
    rst_n = 1'b1;
    advance();

    // 1: MEM hazard holds every register, bubbles only after MEM.
    hz_req = 5'b10000;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t1_stall", stall0, 5'b11111);
      chk("t1_flush", flush0, 5'b10000);
      chk("t1_we", we0, 1'b0);
      advance();
    end
    hz_req   = '0;
    stat_sel = 4'd12;
    settle(); advance();
    settle();
    chk("t1_cyc4", sd0, 3);
    stat_sel = 4'd13;
    advance();
    settle();
    chk("t1_epi4", sd0, 1);
    advance();

    // 2: redirect from stage 2 overrides an IF-only hazard.
    hz_req      = 5'b00001;
    redir_valid = 5'b00100;
    redir_target[2*A +: A] = 32'h400;
    stat_sel    = 4'd8;
    settle();
    chk("t2_stall", stall0, 5'b00000);
    chk("t2_flush_ds1", flush0, 5'b00001);
    chk("t2_flush_ds0", flush1, 5'b00011);
    chk("t2_we", we0, 1'b1);
    chk("t2_pc", pc0, 32'h400);
    advance();
    hz_req = '0; redir_valid = '0;
    settle(); advance();
    settle();
    chk("t2_redir2", sd0, 1);
    chk("t2_redir2_b", sd1, 1);
    advance();

    // 3: oldest of several redirects wins.
    redir_valid = 5'b01110;
    redir_target[1*A +: A] = 32'h100;
    redir_target[2*A +: A] = 32'h200;
    redir_target[3*A +: A] = 32'h300;
    stat_sel = 4'd11;
    settle();
    chk("t3_pc", pc0, 32'h300);
    chk("t3_flush_ds1", flush0, 5'b00011);
    chk("t3_flush_ds0", flush1, 5'b00111);
    advance();
    redir_valid = '0;
    settle(); advance();
    settle();
    chk("t3_redir3", sd0, 1);
    advance();

    // 4: redirect blocked by an older hazard.
    redir_valid = 5'b00100;
    hz_req      = 5'b01000;
    stat_sel    = 4'd8;
    settle();
    chk("t4_we", we0, 1'b0);
    chk("t4_stall", stall0, 5'b01111);
    chk("t4_flush", flush0, 5'b01000);
    chk("t4_pc", pc0, 32'h0);
    advance();
    hz_req = '0; redir_valid = '0;
    settle(); advance();
    settle();
    chk("t4_redir2", sd0, 1);
    advance();

    // 5: watchdog fires after WD stalled cycles, sticky until clear.
    stat_clear = 1'b1;
    settle(); advance();
    stat_clear = 1'b0;
    hz_req     = 5'b00010;
    for (int i = 0; i < WD; i++) begin
      settle();
      chk("t5_dl_early", dl0, 1'b0);
      advance();
    end
    settle();
    chk("t5_dl_set", dl0, 1'b1);
    chk("t5_dl_set_b", dl1, 1'b1);
    advance();
    hz_req = '0;
    repeat (3) begin settle(); advance(); end
    settle();
    chk("t5_dl_sticky", dl0, 1'b1);
    stat_clear = 1'b1;
    advance();
    stat_clear = 1'b0;
    settle();
    chk("t5_dl_clr", dl0, 1'b0);
    stat_sel = '0;
    advance();
    for (int i = 0; i < NC; i++) begin
      settle();
      chk("t5_cnt_zero", sd0, 0);
      stat_sel = SW'(i + 1);
      advance();
    end

    // 6: saturation, out-of-range select, asynchronous reset.
    stat_sel = '0;
    hz_req   = 5'b00001;
    repeat (20) begin settle(); advance(); end
    hz_req = '0;
    settle();
    chk("t6_sat", sd0, 15);
    chk("t6_dl", dl0, 1'b1);
    stat_sel = 4'd15;
    advance();
    settle();
    chk("t6_oob", sd0, 0);
    stat_sel = '0;
    advance();
    settle();
    chk("t6_sat_again", sd0, 15);
    advance();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_sd", sd0, 0);
    chk("t6_arst_dl", dl0, 0);
    chk("t6_arst_sd_b", sd1, 0);
    chk("t6_arst_dl_b", dl1, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    settle(); advance();
    settle();
    chk("t6_post_rst", sd0, 0);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, budget 200000 expected less");
    $fatal(1);
  end

endmodule

// File: doc/hazard_unit_gen.md
Name: hazard_unit_gen

Overview:
Parametrised, N-stage generalisation of the pipeline hazard controller.
- Per-stage hazard requests in; per-register stall/flush and PC redirect out.
- Arbitrates redirects from any stage; optional delay-slot protection.
- Adds saturating per-stage statistics counters with registered readout and a stall-deadlock watchdog.
- Sits beside the core pipeline, replacing the fixed 5-stage controller.

Parameters:
NUM_STAGES, 5, stages before WB (index 0 = IF, NUM_STAGES-1 = MEM)
ADDR_W, 32, PC width
CNT_W, 32, statistics counter width
DELAY_SLOT, 1, 1 = stage r-1 survives a redirect from stage r
WDOG_CYCLES, 1024, consecutive IF-stall cycles before deadlock flag (must be >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
hz_req  in  NUM_STAGES  bit s: stage s cannot complete this cycle
redir_valid  in  NUM_STAGES  bit r: stage r requests a PC redirect; bit 0 ignored
redir_target  in  NUM_STAGES*ADDR_W  target for stage r at [r*ADDR_W +: ADDR_W]
stall_o  out  NUM_STAGES  bit s: hold the register feeding stage s (bit 0 = PC register)
flush_o  out  NUM_STAGES  bit s: bubble the register after stage s
load_pc_we  out  1  redirect accepted
load_pc_new_pc  out  ADDR_W  redirect target
stat_clear  in  1  synchronous clear of counters, watchdog and deadlock
stat_sel  in  $clog2(3*NUM_STAGES)  counter select
stat_data  out  CNT_W  selected counter, registered
deadlock  out  1  sticky watchdog flag

Behaviour:
Combinational, no reset:
- Blocking chain: b[NUM_STAGES-1] = hz_req[NUM_STAGES-1]; b[s] = hz_req[s] | b[s+1] for s >= 1.
- Redirect acceptance: acc = ~b[1] & (|redir_valid[NUM_STAGES-1:1]).
  - Winner r = highest-index valid bit (oldest instruction).
  - load_pc_we = acc; load_pc_new_pc = target[r] when acc, else 0.
- stall_o[s] = b[s] for s >= 1.
- stall_o[0] = (hz_req[0] & ~acc) | b[1]. A redirect overrides an IF-only hazard, because the I-cache does not register missed requests.
- flush_o[s] = hz_req[s] | (acc & s < r - DELAY_SLOT). With DELAY_SLOT=1 and r=1, the redirect flushes nothing.

Sequential, async reset: all counters, prev_hz, wdog_cnt, stat_data and deadlock reset to 0.
- Counter map (index 3s+k):
  - k=0: cycles with hz_req[s] = 1.
  - k=1: hazard episodes, counted when hz_req[s] & ~prev_hz[s]; prev_hz resets to 0, so a hazard in the first cycle after reset counts.
  - k=2: accepted redirects with winner r = s.
- Counters saturate at all-ones and never wrap.
- stat_clear beats increment in the same cycle: the counter becomes 0.
- stat_data <= counter[stat_sel] on each edge (1-cycle latency). Out-of-range stat_sel gives 0.
- Watchdog:
  - wdog_cnt increments while stall_o[0] & ~load_pc_we, else resets to 0.
  - When it reaches WDOG_CYCLES-1 while still stalling, deadlock sets on that edge, i.e. visible after the WDOG_CYCLES-th stalled cycle.
  - deadlock stays set until stat_clear or reset; stat_clear also zeroes wdog_cnt.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Test Plan:
1. Defaults, hz_req=5'b10000 for 3 cycles -> stall_o=5'b11111, flush_o=5'b10000, load_pc_we=0; then stat_sel=12 gives 3 and stat_sel=13 gives 1, each one cycle after select.
2. hz_req=5'b00001, redir_valid=5'b00100, target[2]=0x400 -> stall_o=0, flush_o=5'b00001, load_pc_we=1, new_pc=0x400; stat_sel=8 gives 1. Repeat with DELAY_SLOT=0 -> flush_o=5'b00011.
3. redir_valid=5'b01110, target[1..3]=0x100/0x200/0x300 -> new_pc=0x300, flush_o=5'b00011; stat_sel=11 gives 1.
4. redir_valid=5'b00100 with hz_req=5'b01000 -> load_pc_we=0, stall_o=5'b01111, flush_o=5'b01000; redirect counter unchanged.
5. WDOG_CYCLES=8, hz_req[1] held -> deadlock=0 through the 8th stalled cycle and 1 after it, staying 1 after the hazard drops; stat_clear -> deadlock=0 and all counters read 0.
6. CNT_W=4, hz_req[0] held 20 cycles -> stat_sel=0 gives 15 (saturated). Assert rst_n=0 asynchronously mid-run -> stat_data and deadlock are 0 before the next clk edge.
